// File: rtl/mem_req_pkg.sv
// -----------------------------------------------------------------------------
// mem_req_pkg
// Shared definitions for the processor-side memory request path.
//   - cntrl encodings driven to the memory module (also used by the cache
//     controller, so both sides decode the same constants)
//   - state encoding of the mem_request_unit FSM
// -----------------------------------------------------------------------------
package mem_req_pkg;

    localparam logic [1:0] CNTRL_NOP   = 2'b00;
    localparam logic [1:0] CNTRL_READ  = 2'b01;
    localparam logic [1:0] CNTRL_WRITE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BUSY  = 2'b01,
        ST_DONE  = 2'b10,
        ST_ERROR = 2'b11
    } state_t;

endpackage : mem_req_pkg

// File: rtl/mem_request_unit_wait_timer.sv
// -----------------------------------------------------------------------------
// wait_timer
// Watchdog for an outstanding memory access. Counts the cycles during which
// run is high and flags the last permitted cycle.
// Ports:
//   clk      in   clock, rising edge
//   clr      in   asynchronous active-high reset
//   run      in   count enable; the count clears whenever run is low
//   expired  out  high during the timeoutCycles-th consecutive run cycle
// -----------------------------------------------------------------------------
module wait_timer #(
    parameter int timeoutCycles = 64
) (
    input  logic clk,
    input  logic clr,
    input  logic run,
    output logic expired
);

    localparam int CNT_W = $clog2(timeoutCycles + 1);
    // The count holds (cycles already spent), so the current cycle is number
    // cnt_q+1; reaching timeoutCycles therefore means cnt_q == timeoutCycles-1.
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(timeoutCycles - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!run) begin
            cnt_d = '0;
        end else if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = run && (cnt_q == LIMIT);

endmodule : wait_timer

// File: rtl/mem_request_unit.sv
// -----------------------------------------------------------------------------
// mem_request_unit
// Memory access stage between the execute stage and the memory module
// (cache + data RAM + controller). Accepts one load/store at a time, holds the
// memory-side command stable until dataReady, returns load data with a
// one-cycle valid pulse and stalls the pipeline meanwhile. A watchdog turns a
// hung access into a sticky error that only clr clears.
// Ports:
//   clk, clr                 clock / asynchronous active-high reset
//   reqValid/reqWrite/reqIndirect/reqAddr/reqData   request from execute
//   reqReady                 request accepted when high together with reqValid
//   busy                     pipeline stall (state != IDLE)
//   respValid/respData       completion pulse and load result
//   errFlag                  sticky watchdog error
//   memCntrl/memAddr/memDataIn/memIndirect   command to memory module
//   memDataReady/memDataOut  completion and read data from memory module
// -----------------------------------------------------------------------------
module mem_request_unit
    import mem_req_pkg::*;
#(
    parameter int ramWidth      = 8,
    parameter int addrSize      = 8,
    parameter int timeoutCycles = 64
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                reqValid,
    input  logic                reqWrite,
    input  logic                reqIndirect,
    input  logic [addrSize-1:0] reqAddr,
    input  logic [ramWidth-1:0] reqData,
    output logic                reqReady,
    output logic                busy,
    output logic                respValid,
    output logic [ramWidth-1:0] respData,
    output logic                errFlag,
    output logic [1:0]          memCntrl,
    output logic [addrSize-1:0] memAddr,
    output logic [ramWidth-1:0] memDataIn,
    output logic                memIndirect,
    input  logic                memDataReady,
    input  logic [ramWidth-1:0] memDataOut
);

    state_t state_q, state_d;

    logic                first_busy_q, first_busy_d;
    logic [1:0]          mem_cntrl_q, mem_cntrl_d;
    logic [addrSize-1:0] mem_addr_q, mem_addr_d;
    logic [ramWidth-1:0] mem_data_in_q, mem_data_in_d;
    logic                mem_indirect_q, mem_indirect_d;
    logic [ramWidth-1:0] resp_data_q, resp_data_d;
    logic                resp_valid_q, resp_valid_d;
    logic                err_flag_q, err_flag_d;

    logic timer_run;
    logic expired;
    logic accept;
    logic ready_ok;

    assign timer_run = (state_q == ST_BUSY);
    assign accept    = (state_q == ST_IDLE) && reqValid;
    // dataReady may still be high from the previous access during the first
    // BUSY cycle, so it only qualifies from the second BUSY cycle onward.
    assign ready_ok  = (state_q == ST_BUSY) && !first_busy_q && memDataReady;

    wait_timer #(
        .timeoutCycles(timeoutCycles)
    ) u_wait_timer (
        .clk    (clk),
        .clr    (clr),
        .run    (timer_run),
        .expired(expired)
    );

    // State register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a ready in the timeout cycle takes priority.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (reqValid) state_d = ST_BUSY;
            ST_BUSY: begin
                if (ready_ok) begin
                    state_d = ST_DONE;
                end else if (expired) begin
                    state_d = ST_ERROR;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output logic: combinational handshake plus next values of the
    // registered outputs.
    always_comb begin
        reqReady       = (state_q == ST_IDLE);
        busy           = (state_q != ST_IDLE);
        first_busy_d   = 1'b0;
        mem_cntrl_d    = mem_cntrl_q;
        mem_addr_d     = mem_addr_q;
        mem_data_in_d  = mem_data_in_q;
        mem_indirect_d = mem_indirect_q;
        resp_data_d    = resp_data_q;
        resp_valid_d   = 1'b0;
        err_flag_d     = err_flag_q;

        if (accept) begin
            first_busy_d   = 1'b1;
            mem_cntrl_d    = reqWrite ? CNTRL_WRITE : CNTRL_READ;
            mem_addr_d     = reqAddr;
            mem_data_in_d  = reqData;
            mem_indirect_d = reqIndirect;
        end else if (ready_ok) begin
            mem_cntrl_d  = CNTRL_NOP;
            resp_valid_d = 1'b1;
            if (mem_cntrl_q == CNTRL_READ) begin
                resp_data_d = memDataOut;
            end
        end else if (timer_run && expired) begin
            mem_cntrl_d = CNTRL_NOP;
            err_flag_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            first_busy_q   <= 1'b0;
            mem_cntrl_q    <= CNTRL_NOP;
            mem_addr_q     <= '0;
            mem_data_in_q  <= '0;
            mem_indirect_q <= 1'b0;
            resp_data_q    <= '0;
            resp_valid_q   <= 1'b0;
            err_flag_q     <= 1'b0;
        end else begin
            first_busy_q   <= first_busy_d;
            mem_cntrl_q    <= mem_cntrl_d;
            mem_addr_q     <= mem_addr_d;
            mem_data_in_q  <= mem_data_in_d;
            mem_indirect_q <= mem_indirect_d;
            resp_data_q    <= resp_data_d;
            resp_valid_q   <= resp_valid_d;
            err_flag_q     <= err_flag_d;
        end
    end

    assign memCntrl    = mem_cntrl_q;
    assign memAddr     = mem_addr_q;
    assign memDataIn   = mem_data_in_q;
    assign memIndirect = mem_indirect_q;
    assign respData    = resp_data_q;
    assign respValid   = resp_valid_q;
    assign errFlag     = err_flag_q;

endmodule : mem_request_unit

// File: tb/tb_mem_request_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_request_unit
// Directed bench for mem_request_unit with timeoutCycles = 8. The bench plays
// the memory module by driving memDataReady / memDataOut directly. Inputs are
// changed and outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_mem_request_unit;

    logic       clk = 1'b0;
    logic       clr;
    logic       reqValid, reqWrite, reqIndirect;
    logic [7:0] reqAddr, reqData;
    logic       reqReady, busy, respValid, errFlag;
    logic [7:0] respData;
    logic [1:0] memCntrl;
    logic [7:0] memAddr, memDataIn;
    logic       memIndirect;
    logic       memDataReady;
    logic [7:0] memDataOut;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mem_request_unit #(
        .ramWidth     (8),
        .addrSize     (8),
        .timeoutCycles(8)
    ) dut (
        .clk         (clk),
        .clr         (clr),
        .reqValid    (reqValid),
        .reqWrite    (reqWrite),
        .reqIndirect (reqIndirect),
        .reqAddr     (reqAddr),
        .reqData     (reqData),
        .reqReady    (reqReady),
        .busy        (busy),
        .respValid   (respValid),
        .respData    (respData),
        .errFlag     (errFlag),
        .memCntrl    (memCntrl),
        .memAddr     (memAddr),
        .memDataIn   (memDataIn),
        .memIndirect (memIndirect),
        .memDataReady(memDataReady),
        .memDataOut  (memDataOut)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [7:0] addr, input logic [7:0] data);
        reqValid = 1'b1;
        reqWrite = wr;
        reqAddr  = addr;
        reqData  = data;
    endtask

    initial begin
        clr = 1'b1;
        reqValid = 1'b0; reqWrite = 1'b0; reqIndirect = 1'b0;
        reqAddr = 8'h00; reqData = 8'h00;
        memDataReady = 1'b0; memDataOut = 8'h00;
        #2;
        chk("rst_reqReady",  8'(reqReady),  8'd1);
        chk("rst_busy",      8'(busy),      8'd0);
        chk("rst_memCntrl",  8'(memCntrl),  8'd0);
        chk("rst_respValid", 8'(respValid), 8'd0);
        chk("rst_errFlag",   8'(errFlag),   8'd0);
        chk("rst_respData",  respData,      8'h00);
        chk("rst_memAddr",   memAddr,       8'h00);
        step();
        clr = 1'b0;
        step();

        // ---- Load 0x10, ready in 2nd BUSY cycle with 0xA5 ----
        issue(1'b0, 8'h10, 8'h00);
        reqIndirect = 1'b1;
        step();                                   // accept edge t0
        reqValid = 1'b0; reqIndirect = 1'b0;
        chk("ld_busy",      8'(busy),        8'd1);
        chk("ld_reqReady",  8'(reqReady),    8'd0);
        chk("ld_cntrl_c1",  8'(memCntrl),    8'd1);
        chk("ld_addr",      memAddr,         8'h10);
        chk("ld_indirect",  8'(memIndirect), 8'd1);
        step();                                   // t0+1
        chk("ld_cntrl_c2",  8'(memCntrl),    8'd1);
        chk("ld_noresp_c2", 8'(respValid),   8'd0);
        memDataReady = 1'b1; memDataOut = 8'hA5;
        step();                                   // t0+2
        memDataReady = 1'b0;
        chk("ld_cntrl_nop", 8'(memCntrl),    8'd0);
        chk("ld_respValid", 8'(respValid),   8'd1);
        chk("ld_respData",  respData,        8'hA5);
        step();                                   // t0+3
        chk("ld_resp_once", 8'(respValid),   8'd0);
        chk("ld_idle_busy", 8'(busy),        8'd0);

        // ---- Store 0x3C to 0x20 ----
        issue(1'b1, 8'h20, 8'h3C);
        step();
        reqValid = 1'b0;
        chk("st_cntrl",     8'(memCntrl),    8'd2);
        chk("st_dataIn",    memDataIn,       8'h3C);
        chk("st_addr",      memAddr,         8'h20);
        step();
        chk("st_cntrl_hold", 8'(memCntrl),   8'd2);
        chk("st_data_hold", memDataIn,       8'h3C);
        memDataReady = 1'b1; memDataOut = 8'hFF;
        step();
        memDataReady = 1'b0;
        chk("st_cntrl_nop", 8'(memCntrl),    8'd0);
        chk("st_respValid", 8'(respValid),   8'd1);
        chk("st_respData",  respData,        8'hA5);
        step();
        chk("st_resp_once", 8'(respValid),   8'd0);

        // ---- Stale ready: memDataReady held high ----
        memDataReady = 1'b1; memDataOut = 8'h5A;
        issue(1'b0, 8'h30, 8'h00);
        step();                                   // t0
        reqValid = 1'b0;
        chk("sr_cntrl_c1",  8'(memCntrl),    8'd1);
        step();                                   // t0+1: ready ignored
        chk("sr_ignored",   8'(respValid),   8'd0);
        chk("sr_cntrl_c2",  8'(memCntrl),    8'd1);
        step();                                   // t0+2
        chk("sr_respValid", 8'(respValid),   8'd1);
        chk("sr_respData",  respData,        8'h5A);
        step();                                   // t0+3
        chk("sr_idle",      8'(busy),        8'd0);
        chk("sr_resp_once", 8'(respValid),   8'd0);
        memDataReady = 1'b0;

        // ---- Back-to-back: reqValid held for 0x01 then 0x02 ----
        issue(1'b0, 8'h01, 8'h00);
        step();                                   // t0 accept 0x01
        reqAddr = 8'h02;
        chk("bb_addr1",     memAddr,         8'h01);
        step();                                   // t0+1
        chk("bb_hold_busy", memAddr,         8'h01);
        memDataReady = 1'b1; memDataOut = 8'h11;
        step();                                   // t0+2 DONE
        memDataReady = 1'b0;
        chk("bb_resp1",     respData,        8'h11);
        chk("bb_hold_done", memAddr,         8'h01);
        chk("bb_done_rdy",  8'(reqReady),    8'd0);
        step();                                   // t0+3 IDLE
        chk("bb_idle_rdy",  8'(reqReady),    8'd1);
        chk("bb_nop_gap",   8'(memCntrl),    8'd0);
        chk("bb_not_yet",   memAddr,         8'h01);
        step();                                   // t0+4 accept 0x02
        reqValid = 1'b0;
        chk("bb_addr2",     memAddr,         8'h02);
        chk("bb_cntrl2",    8'(memCntrl),    8'd1);
        step();
        memDataReady = 1'b1; memDataOut = 8'h22;
        step();
        memDataReady = 1'b0;
        chk("bb_resp2",     respData,        8'h22);
        step();

        // ---- Ready arrives in the timeout cycle: ready wins ----
        issue(1'b0, 8'h44, 8'h00);
        step();                                   // BUSY cycle 1
        reqValid = 1'b0;
        for (int i = 0; i < 7; i++) step();       // BUSY cycle 8
        chk("rw_still_busy", 8'(memCntrl),   8'd1);
        memDataReady = 1'b1; memDataOut = 8'h77;
        step();
        memDataReady = 1'b0;
        chk("rw_respValid", 8'(respValid),   8'd1);
        chk("rw_noerr",     8'(errFlag),     8'd0);
        chk("rw_respData",  respData,        8'h77);
        step();

        // ---- Timeout: ready never arrives ----
        issue(1'b0, 8'h40, 8'h00);
        step();                                   // BUSY cycle 1
        reqValid = 1'b0;
        for (int i = 0; i < 7; i++) step();       // BUSY cycle 8
        chk("to_noerr_c8",  8'(errFlag),     8'd0);
        chk("to_cntrl_c8",  8'(memCntrl),    8'd1);
        step();                                   // ERROR
        chk("to_errFlag",   8'(errFlag),     8'd1);
        chk("to_cntrl_nop", 8'(memCntrl),    8'd0);
        chk("to_busy",      8'(busy),        8'd1);
        chk("to_reqReady",  8'(reqReady),    8'd0);
        chk("to_no_resp",   8'(respValid),   8'd0);
        issue(1'b1, 8'h99, 8'h55);
        step();
        step();
        reqValid = 1'b0;
        chk("to_no_accept", memAddr,         8'h40);
        chk("to_sticky",    8'(errFlag),     8'd1);
        clr = 1'b1;
        #1;
        chk("to_clr_err",   8'(errFlag),     8'd0);
        chk("to_clr_busy",  8'(busy),        8'd0);
        chk("to_clr_rdy",   8'(reqReady),    8'd1);
        clr = 1'b0;
        step();

        // ---- Reset between edges during a read ----
        issue(1'b0, 8'h50, 8'h00);
        step();
        reqValid = 1'b0;
        step();
        #2;
        clr = 1'b1;
        #1;
        chk("mr_cntrl",     8'(memCntrl),    8'd0);
        chk("mr_busy",      8'(busy),        8'd0);
        chk("mr_respValid", 8'(respValid),   8'd0);
        chk("mr_addr",      memAddr,         8'h00);
        #1;
        clr = 1'b0;
        step();
        issue(1'b0, 8'h10, 8'h00);
        step();
        reqValid = 1'b0;
        chk("mr2_cntrl",    8'(memCntrl),    8'd1);
        chk("mr2_addr",     memAddr,         8'h10);
        step();
        memDataReady = 1'b1; memDataOut = 8'hC3;
        step();
        memDataReady = 1'b0;
        chk("mr2_respValid", 8'(respValid),  8'd1);
        chk("mr2_respData", respData,        8'hC3);
        step();
        chk("mr2_idle",     8'(busy),        8'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_mem_request_unit

// File: doc/mem_request_unit.md
# mem_request_unit

Processor-side memory access stage that sits directly upstream of the memory module (cache + data RAM + cache controller). It accepts one load/store request at a time from the execute stage and drives the memory module's `cntrl`/`addr`/`dataIn`/`isIndirect` inputs, holding them stable until the module's `dataReady`. It then returns read data with a one-cycle valid pulse and stalls the pipeline while the access is outstanding. A wait-cycle watchdog converts a hung access into a sticky error.

## Interface
- `ramWidth`, 8, data word width
- `addrSize`, 8, address width
- `timeoutCycles`, 64, maximum BUSY cycles before error; legal range ≥ 4
- `clk`  in  1  system clock, rising edge
- `clr`  in  1  reset, asynchronous, active-high
- `reqValid`  in  1  request present from execute stage
- `reqWrite`  in  1  1 = store, 0 = load
- `reqIndirect`  in  1  indirect access, passed to memory module
- `reqAddr`  in  addrSize  request address
- `reqData`  in  ramWidth  store data
- `reqReady`  out  1  request accepted this cycle when high with `reqValid`
- `busy`  out  1  stall to pipeline, high whenever state ≠ IDLE
- `respValid`  out  1  one-cycle completion pulse
- `respData`  out  ramWidth  load result
- `errFlag`  out  1  sticky watchdog error
- `memCntrl`  out  2  to memory module `cntrl`
- `memAddr`  out  addrSize  to `addr`
- `memDataIn`  out  ramWidth  to `dataIn`
- `memIndirect`  out  1  to `isIndirect`
- `memDataReady`  in  1  from `dataReady`
- `memDataOut`  in  ramWidth  from `dataOut`

## Operation
- `cntrl` encoding: 2'b00 NOP, 2'b01 READ, 2'b10 WRITE; 2'b11 is never driven.
- States: IDLE, BUSY, DONE, ERROR.
- IDLE: `reqReady` = 1. On `reqValid`, go to BUSY and register `memAddr`, `memDataIn`, `memIndirect`, and `memCntrl` (READ or WRITE).
- BUSY: all `mem*` outputs are held constant. `memDataReady` is ignored in the first BUSY cycle because it may be stale from the previous access. From the second BUSY cycle onward, `memDataReady` = 1 causes these actions:
  - `memCntrl` goes to NOP.
  - For a read, `respData` is loaded with `memDataOut`.
  - The state goes to DONE.
- DONE: `respValid` = 1 for exactly one cycle, then IDLE. `respValid` pulses for writes too; `respData` is unchanged on writes.
- Watchdog: counts BUSY cycles, including the first. If the count reaches `timeoutCycles` with no qualifying ready, the block goes to ERROR, sets `memCntrl` to NOP, and sets `errFlag` to 1. `respValid` is not pulsed. ERROR is left only by `clr`; `reqReady` = 0 and `busy` = 1 while in ERROR.
- If `memDataReady` arrives in the same cycle as the timeout, ready wins and the block goes to DONE.
- Reset values: state IDLE; `memCntrl` = NOP; `memAddr`, `memDataIn`, `respData` = 0; `memIndirect`, `respValid`, `errFlag`, `busy` = 0; `reqReady` = 1; counter = 0.

## Timing
- Accept edge t0. BUSY covers cycles t0+1 onward. The earliest qualifying ready is sampled at edge t0+2, `respValid` is high during t0+2..t0+3, and IDLE returns at t0+3.
- Minimum request-to-response latency is 3 cycles. Back-to-back requests are spaced at least 4 cycles apart.
- At least one NOP cycle on `memCntrl` separates successive accesses.
- `reqReady` and `busy` are combinational from state only. All other outputs are registered.
- `clr` asserted mid-access forces every output to its reset value without waiting for a clock edge, including `memCntrl` = NOP. No response is produced for the aborted request.

## Structure
- Package `mem_req_pkg` holds the `cntrl` encodings (`CNTRL_NOP`, `CNTRL_READ`, `CNTRL_WRITE`) and the state encoding. The cache controller shares the same `cntrl` constants.
- Sub-module `wait_timer` implements the watchdog:
  - Counter width is `$clog2(timeoutCycles+1)`.
  - Inputs `clk`, `clr`, `run`; output `expired`.
  - The counter clears whenever `run` = 0.

## Test plan
- Load: reqAddr=0x10, memDataReady rises in the 2nd BUSY cycle with memDataOut=0xA5. Required: memCntrl=01 for 2 cycles then 00; respValid pulses once; respData=0xA5.
- Store: reqAddr=0x20, reqData=0x3C. Required: memCntrl=10, memDataIn=0x3C held until ready; respValid pulses; respData keeps its prior value.
- Stale ready: memDataReady tied high. Required: ignored in the 1st BUSY cycle; respValid at t0+2; total latency exactly 3.
- Timeout: timeoutCycles=8, memDataReady never high. Required:
  - errFlag=1 after the 8th BUSY cycle, and memCntrl=00.
  - A new reqValid is not accepted.
  - `clr` returns the block to IDLE with errFlag=0.
- Back-to-back: reqValid held high for two requests, 0x01 then 0x02. Required: the second is accepted only in the IDLE cycle after DONE, with one or more NOP cycles on memCntrl between the two accesses.
- Reset mid-BUSY: assert `clr` between clock edges during a read. Required: memCntrl=00, busy=0, and respValid=0 immediately. A subsequent read of 0x10 completes normally.
